minmax_cmp_sequencer: RTL and testbench

// - Frame-based min/max finder that time-shares ONE NbitComparator instance for both compares.
// - Accepts FRAME_LEN unsigned samples over a valid/ready stream.
// - Sequences the comparator (min compare, then max compare) for each sample.
// - Reports frame min/max with a one-cycle done pulse.
// - Sits between a sample source and downstream statistics/threshold logic.

---
 rtl/minmax_cmp_sequencer.sv | 235 +++++++++++++++++++++++
 tb/tb_minmax_cmp_sequencer.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/minmax_cmp_sequencer.sv
// Frame min/max finder built around one shared magnitude comparator.
// Each frame takes FRAME_LEN unsigned samples over a valid/ready stream.
// The first sample seeds both running extremes. Every later sample costs
// two compare cycles on the shared comparator: first against the running
// min, then against the running max. The results are published with a
// one-cycle done pulse.
// Optional build macro: MINMAX_INDEX_EN adds min_idx/max_idx outputs, which
// give the 0-based position of the first occurrence of each extreme.

module nbit_comparator #(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         lt,
    output logic         gt
);
    // Unsigned magnitude compare.
    always_comb begin
        lt = (a < b);
        gt = (a > b);
    end
endmodule

module minmax_cmp_sequencer #(
    parameter int   N         = 8,
    parameter int   FRAME_LEN = 16,
    localparam int  CW        = $clog2(FRAME_LEN + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_data,
    output logic          busy,
    output logic          done,
    output logic [N-1:0]  min_out,
    output logic [N-1:0]  max_out
`ifdef MINMAX_INDEX_EN
    ,
    output logic [CW-1:0] min_idx,
    output logic [CW-1:0] max_idx
`endif
);
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] ACCEPT  = 3'd1;
    localparam logic [2:0] CMP_MIN = 3'd2;
    localparam logic [2:0] CMP_MAX = 3'd3;
    localparam logic [2:0] DONE    = 3'd4;

    localparam int          FL_INT   = FRAME_LEN;
    localparam logic [CW-1:0] FULL_CNT = FL_INT[CW-1:0];

    logic [2:0]    state_reg, state_next;
    logic [CW-1:0] count_reg, count_next;
    logic [N-1:0]  smp_reg, smp_next;
    logic [N-1:0]  min_w_reg, min_w_next;
    logic [N-1:0]  max_w_reg, max_w_next;
    logic [N-1:0]  min_out_reg, min_out_next;
    logic [N-1:0]  max_out_reg, max_out_next;
    logic          done_reg, done_next;
`ifdef MINMAX_INDEX_EN
    logic [CW-1:0] smp_idx_reg, smp_idx_next;
    logic [CW-1:0] min_iw_reg, min_iw_next;
    logic [CW-1:0] max_iw_reg, max_iw_next;
    logic [CW-1:0] min_idx_reg, min_idx_next;
    logic [CW-1:0] max_idx_reg, max_idx_next;
`endif

    logic [N-1:0]  cmp_b;
    logic          cmp_lt;
    logic          cmp_gt;

    // The single comparator always sees the held sample on a; b is the running max in CMP_MAX, otherwise the running min.
    always_comb begin
        cmp_b = (state_reg == CMP_MAX) ? max_w_reg : min_w_reg;
    end

    nbit_comparator #(.N(N)) u_cmp (
        .a  (smp_reg),
        .b  (cmp_b),
        .lt (cmp_lt),
        .gt (cmp_gt)
    );

    // Sequencer next-state and datapath updates; ties never replace an extreme, so the first occurrence is kept.
    always_comb begin
        state_next   = state_reg;
        count_next   = count_reg;
        smp_next     = smp_reg;
        min_w_next   = min_w_reg;
        max_w_next   = max_w_reg;
        min_out_next = min_out_reg;
        max_out_next = max_out_reg;
        done_next    = 1'b0;
`ifdef MINMAX_INDEX_EN
        smp_idx_next = smp_idx_reg;
        min_iw_next  = min_iw_reg;
        max_iw_next  = max_iw_reg;
        min_idx_next = min_idx_reg;
        max_idx_next = max_idx_reg;
`endif
        case (state_reg)
            ACCEPT: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (in_valid) begin
                    smp_next   = in_data;
                    count_next = count_reg + 1'b1;
`ifdef MINMAX_INDEX_EN
                    smp_idx_next = count_reg;
`endif
                    if (count_reg == '0) begin
                        min_w_next = in_data;
                        max_w_next = in_data;
`ifdef MINMAX_INDEX_EN
                        min_iw_next = '0;
                        max_iw_next = '0;
`endif
                        if (FRAME_LEN == 1) begin
                            state_next   = DONE;
                            done_next    = 1'b1;
                            min_out_next = in_data;
                            max_out_next = in_data;
`ifdef MINMAX_INDEX_EN
                            min_idx_next = '0;
                            max_idx_next = '0;
`endif
                        end
                    end else begin
                        state_next = CMP_MIN;
                    end
                end
            end
            CMP_MIN: begin
                if (abort) begin
                    state_next = IDLE;
                end else begin
                    if (cmp_lt) begin
                        min_w_next = smp_reg;
`ifdef MINMAX_INDEX_EN
                        min_iw_next = smp_idx_reg;
`endif
                    end
                    state_next = CMP_MAX;
                end
            end
            CMP_MAX: begin
                if (abort) begin
                    state_next = IDLE;
                end else begin
                    if (cmp_gt) begin
                        max_w_next = smp_reg;
`ifdef MINMAX_INDEX_EN
                        max_iw_next = smp_idx_reg;
`endif
                    end
                    if (count_reg == FULL_CNT) begin
                        state_next   = DONE;
                        done_next    = 1'b1;
                        min_out_next = min_w_reg;
                        max_out_next = max_w_next;
`ifdef MINMAX_INDEX_EN
                        min_idx_next = min_iw_reg;
                        max_idx_next = max_iw_next;
`endif
                    end else begin
                        state_next = ACCEPT;
                    end
                end
            end
            default: begin
                // IDLE and DONE: only start matters here.
                if (start) begin
                    state_next = ACCEPT;
                    count_next = '0;
                end else begin
                    state_next = IDLE;
                end
            end
        endcase
    end

    // State and datapath registers; reset clears the partial frame and the published results.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            count_reg   <= '0;
            smp_reg     <= '0;
            min_w_reg   <= '0;
            max_w_reg   <= '0;
            min_out_reg <= '0;
            max_out_reg <= '0;
            done_reg    <= 1'b0;
`ifdef MINMAX_INDEX_EN
            smp_idx_reg <= '0;
            min_iw_reg  <= '0;
            max_iw_reg  <= '0;
            min_idx_reg <= '0;
            max_idx_reg <= '0;
`endif
        end else begin
            state_reg   <= state_next;
            count_reg   <= count_next;
            smp_reg     <= smp_next;
            min_w_reg   <= min_w_next;
            max_w_reg   <= max_w_next;
            min_out_reg <= min_out_next;
            max_out_reg <= max_out_next;
            done_reg    <= done_next;
`ifdef MINMAX_INDEX_EN
            smp_idx_reg <= smp_idx_next;
            min_iw_reg  <= min_iw_next;
            max_iw_reg  <= max_iw_next;
            min_idx_reg <= min_idx_next;
            max_idx_reg <= max_idx_next;
`endif
        end
    end

    // Status outputs decoded from the current state.
    always_comb begin
        in_ready = (state_reg == ACCEPT);
        busy     = (state_reg == ACCEPT) || (state_reg == CMP_MIN) || (state_reg == CMP_MAX);
        done     = done_reg;
        min_out  = min_out_reg;
        max_out  = max_out_reg;
`ifdef MINMAX_INDEX_EN
        min_idx  = min_idx_reg;
        max_idx  = max_idx_reg;
`endif
    end
endmodule

// File: tb/tb_minmax_cmp_sequencer.sv
// Bench for minmax_cmp_sequencer: a FRAME_LEN=4 instance checked every cycle
// against a frame-level model, plus a FRAME_LEN=1 instance checked with
// literal values. Index outputs are checked when MINMAX_INDEX_EN is defined.

module tb_minmax_cmp_sequencer;
    localparam int L    = 4;
    localparam int CW4  = $clog2(L + 1);
    localparam int CW1  = $clog2(2);

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0, abort = 1'b0, in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic in_ready, busy, done;
    logic [7:0] min_out, max_out;
    logic [CW4-1:0] min_idx, max_idx;

    logic b_start = 1'b0, b_abort = 1'b0, b_valid = 1'b0;
    logic [7:0] b_data = 8'h00;
    logic b_ready, b_busy, b_done;
    logic [7:0] b_min, b_max;
    logic [CW1-1:0] b_min_idx, b_max_idx;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    minmax_cmp_sequencer #(.N(8), .FRAME_LEN(L)) dut4 (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .busy(busy), .done(done), .min_out(min_out), .max_out(max_out)
`ifdef MINMAX_INDEX_EN
        , .min_idx(min_idx), .max_idx(max_idx)
`endif
    );

    minmax_cmp_sequencer #(.N(8), .FRAME_LEN(1)) dut1 (
        .clk(clk), .rst(rst), .start(b_start), .abort(b_abort),
        .in_valid(b_valid), .in_ready(b_ready), .in_data(b_data),
        .busy(b_busy), .done(b_done), .min_out(b_min), .max_out(b_max)
`ifdef MINMAX_INDEX_EN
        , .min_idx(b_min_idx), .max_idx(b_max_idx)
`endif
    );

`ifndef MINMAX_INDEX_EN
    assign min_idx   = '0;
    assign max_idx   = '0;
    assign b_min_idx = '0;
    assign b_max_idx = '0;
`endif

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- frame-level model of the FRAME_LEN=4 instance ----------------
    // Throughput rule: the first sample is taken in one cycle, each later sample
    // blocks the input for two further cycles, and the last sample is followed
    // by two cycles before the done pulse.
    bit         m_active = 0;
    int         m_cd     = -1;
    int         m_wait   = 0;
    logic [7:0] m_q[$];
    logic [7:0] e_min = 8'h00, e_max = 8'h00;
    int         e_mini = 0, e_maxi = 0;
    bit         e_done = 0;

    task automatic model_finish();
        e_min = m_q[0]; e_max = m_q[0]; e_mini = 0; e_maxi = 0;
        for (int i = 1; i < m_q.size(); i++) begin
            if (m_q[i] < e_min) begin e_min = m_q[i]; e_mini = i; end
            if (m_q[i] > e_max) begin e_max = m_q[i]; e_maxi = i; end
        end
        e_done = 1; m_active = 0; m_cd = -1; m_wait = 0;
        m_q.delete();
    endtask

    function automatic bit model_ready();
        return m_active && (m_cd < 0) && (m_wait == 0);
    endfunction

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_active = 0; m_cd = -1; m_wait = 0; m_q.delete();
                e_min = 8'h00; e_max = 8'h00; e_mini = 0; e_maxi = 0; e_done = 0;
            end else begin
                bit rdy_e;
                rdy_e  = model_ready();
                e_done = 0;
                if (m_active) begin
                    if (abort) begin
                        m_active = 0; m_cd = -1; m_wait = 0; m_q.delete();
                    end else if (m_cd > 0) begin
                        m_cd--;
                        if (m_cd == 0) model_finish();
                    end else if (m_wait > 0) begin
                        m_wait--;
                    end else if (in_valid && rdy_e) begin
                        m_q.push_back(in_data);
                        if (m_q.size() == L) m_cd = 2;
                        else if (m_q.size() > 1) m_wait = 2;
                    end
                end else if (start) begin
                    m_active = 1; m_cd = -1; m_wait = 0; m_q.delete();
                end
            end
        end
    end

    // Every-cycle comparison of the FRAME_LEN=4 instance against the model.
    initial begin
        forever begin
            @(negedge clk);
            chk("in_ready", int'(in_ready), int'(model_ready()));
            chk("busy",     int'(busy),     int'(m_active));
            chk("done",     int'(done),     int'(e_done));
            chk("min_out",  int'(min_out),  int'(e_min));
            chk("max_out",  int'(max_out),  int'(e_max));
`ifdef MINMAX_INDEX_EN
            chk("min_idx",  int'(min_idx),  e_mini);
            chk("max_idx",  int'(max_idx),  e_maxi);
`endif
        end
    end

    // ---------------- stimulus ----------------
    // Runs one frame on dut4. vpat bit (k%4) gives in_valid on the k-th cycle
    // after start; abort_after>=0 aborts once that many samples were taken.
    task automatic run_frame(input logic [7:0] d0, input logic [7:0] d1,
                             input logic [7:0] d2, input logic [7:0] d3,
                             input logic [3:0] vpat, input int abort_after,
                             input bit keep_start, output int lat);
        logic [7:0] vals[4];
        int idx, k, s0;
        bit rdy, seen;
        vals[0] = d0; vals[1] = d1; vals[2] = d2; vals[3] = d3;
        idx = 0; k = 0; seen = 0; lat = -1;
        start = 1'b1;
        @(posedge clk);
        #1;
        if (!keep_start) start = 1'b0;
        s0 = cyc;
        in_valid = vpat[0];
        in_data  = vals[0];
        for (int t = 0; t < 200 && !seen; t++) begin
            @(negedge clk);
            rdy = in_ready;
            if (done) begin
                seen = 1;
                lat  = cyc - s0;
            end else begin
                @(posedge clk);
                if (in_valid && rdy) idx++;
                #1;
                if (abort_after >= 0 && idx == abort_after) begin
                    abort = 1'b1; in_valid = 1'b0;
                    @(posedge clk);
                    #1 abort = 1'b0;
                    break;
                end
                k++;
                in_valid = (idx < 4) ? vpat[k % 4] : 1'b0;
                in_data  = vals[(idx < 4) ? idx : 3];
            end
        end
        in_valid = 1'b0;
        if (abort_after < 0) chk("frame_completed", int'(seen), 1);
    endtask

    initial begin
        int lat, lat2;
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        int lat, lat2;
        // Reset state
        @(negedge clk);
        chk("reset_busy",  int'(busy), 0);
        chk("reset_ready", int'(in_ready), 0);
        chk("reset_done",  int'(done), 0);
        chk("reset_min",   int'(min_out), 0);
        chk("reset_max",   int'(max_out), 0);
        chk("reset1_busy", int'(b_busy), 0);
        chk("reset1_min",  int'(b_min), 0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // T1 basic
        run_frame(8'h30, 8'h10, 8'h50, 8'h20, 4'b1111, -1, 0, lat);
        chk("T1_latency", lat, 10);
        chk("T1_min", int'(min_out), 8'h10);
        chk("T1_max", int'(max_out), 8'h50);
        $display("T1 basic: lat=%0d min=%02h max=%02h", lat, min_out, max_out);

        // T2 ties / first-occurrence index
        run_frame(8'h40, 8'h40, 8'h05, 8'h05, 4'b1111, -1, 0, lat);
        chk("T2_min", int'(min_out), 8'h05);
        chk("T2_max", int'(max_out), 8'h40);
        chk("T2_model_min_idx", e_mini, 2);
        chk("T2_model_max_idx", e_maxi, 0);
`ifdef MINMAX_INDEX_EN
        chk("T2_min_idx", int'(min_idx), 2);
        chk("T2_max_idx", int'(max_idx), 0);
`endif
        $display("T2 ties: min=%02h max=%02h min_idx=%0d max_idx=%0d", min_out, max_out, min_idx, max_idx);

        // T3 backpressure: in_valid pattern 1,0,0,1
        run_frame(8'hFF, 8'h00, 8'h7F, 8'h80, 4'b1001, -1, 0, lat);
        chk("T3_latency", lat, 14);
        chk("T3_min", int'(min_out), 8'h00);
        chk("T3_max", int'(max_out), 8'hFF);
        $display("T3 backpressure: lat=%0d min=%02h max=%02h", lat, min_out, max_out);

        // T4 abort after 2 samples; previous frame 10/50
        run_frame(8'h30, 8'h10, 8'h50, 8'h20, 4'b1111, -1, 0, lat);
        run_frame(8'h01, 8'hEE, 8'h02, 8'h03, 4'b1111, 2, 0, lat);
        @(negedge clk);
        chk("T4_ready", int'(in_ready), 0);
        chk("T4_busy",  int'(busy), 0);
        chk("T4_done",  int'(done), 0);
        chk("T4_min",   int'(min_out), 8'h10);
        chk("T4_max",   int'(max_out), 8'h50);
        repeat (4) @(negedge clk);
        $display("T4 abort: busy=%0d min=%02h max=%02h", busy, min_out, max_out);
        @(posedge clk); #1;

        // T5 back-to-back: start held through DONE
        run_frame(8'h30, 8'h10, 8'h50, 8'h20, 4'b1111, -1, 1, lat);
        run_frame(8'h01, 8'h02, 8'h03, 8'h04, 4'b1111, -1, 0, lat2);
        chk("T5_lat_a", lat, 10);
        chk("T5_lat_b", lat2, 10);
        chk("T5_min", int'(min_out), 8'h01);
        chk("T5_max", int'(max_out), 8'h04);
        $display("T5 back-to-back: lat_a=%0d lat_b=%0d min=%02h max=%02h", lat, lat2, min_out, max_out);

        // T5 FRAME_LEN=1: done on the 2nd edge counting the one that samples start
        b_start = 1'b1; b_valid = 1'b1; b_data = 8'h3C;
        @(posedge clk);
        @(negedge clk);
        chk("L1_busy_accept", int'(b_busy), 1);
        chk("L1_ready",       int'(b_ready), 1);
        chk("L1_done_early",  int'(b_done), 0);
        @(negedge clk);
        chk("L1_done", int'(b_done), 1);
        chk("L1_min",  int'(b_min), 8'h3C);
        chk("L1_max",  int'(b_max), 8'h3C);
        chk("L1_idx",  int'(b_min_idx) + int'(b_max_idx), 0);
        b_data = 8'h5A;
        @(negedge clk);
        chk("L1_b2b_busy", int'(b_busy), 1);
        chk("L1_b2b_hold", int'(b_min), 8'h3C);
        @(negedge clk);
        chk("L1_done2", int'(b_done), 1);
        chk("L1_min2",  int'(b_min), 8'h5A);
        chk("L1_max2",  int'(b_max), 8'h5A);
        b_start = 1'b0; b_valid = 1'b0;
        @(negedge clk);
        chk("L1_idle_busy", int'(b_busy), 0);
        chk("L1_idle_done", int'(b_done), 0);
        $display("T5 FRAME_LEN=1: min=%02h max=%02h", b_min, b_max);

        // T6 reset during CMP_MIN
        @(posedge clk); #1;
        start = 1'b1; in_valid = 1'b1; in_data = 8'h77;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        in_data = 8'h11;
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("T6_busy",  int'(busy), 0);
        chk("T6_ready", int'(in_ready), 0);
        chk("T6_done",  int'(done), 0);
        chk("T6_min",   int'(min_out), 0);
        chk("T6_max",   int'(max_out), 0);
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
        run_frame(8'h0C, 8'hC0, 8'h0C, 8'hC0, 4'b1111, -1, 0, lat);
        chk("T6_latency", lat, 10);
        chk("T6_min_after", int'(min_out), 8'h0C);
        chk("T6_max_after", int'(max_out), 8'hC0);
`ifdef MINMAX_INDEX_EN
        chk("T6_min_idx", int'(min_idx), 0);
        chk("T6_max_idx", int'(max_idx), 1);
`endif
        $display("T6 reset mid-frame: lat=%0d min=%02h max=%02h", lat, min_out, max_out);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
